axi_read_arbiter: RTL and testbench
===================================

AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 SHALL have port aclk, input, 1: sole clock; all state changes on its rising edge.
REQ-002 SHALL have port aresetn, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port flush, input, 1: pipeline flush; cancels the instruction requester only.
REQ-004 SHALL have ports inst_req (in, 1), inst_addr (in, 32), inst_gnt (out, 1), inst_rvalid (out, 1), inst_rdata (out, 32): fetch requester.
REQ-005 SHALL have ports data_req (in, 1), data_addr (in, 32), data_size (in, 3), data_gnt (out, 1), data_rvalid (out, 1), data_rdata (out, 32): load requester.
REQ-006 SHALL have ports arid (out, 4), araddr (out, 32), arsize (out, 3), arvalid (out, 1), arready (in, 1): AXI AR channel; arlen, arburst, arlock, arcache and arprot are tied off by the parent.
REQ-007 SHALL have ports rid (in, 4), rdata (in, 32), rvalid (in, 1), rready (out, 1): AXI R channel; rresp and rlast are ignored.

Function
REQ-008 SHALL allow at most one outstanding AXI read; states IDLE, ADDR, DATA.
REQ-009 In IDLE with exactly one request pending, SHALL select that requester.
REQ-010 In IDLE with both requests pending, SHALL select the requester not granted last (round-robin; last-granted = inst after reset).
REQ-011 On selection in cycle N, SHALL register arid/araddr/arsize and assert arvalid from cycle N+1; state -> ADDR.
REQ-012 Inst transactions: arid = 0, arsize = 3'b010. Data transactions: arid = 1, arsize = data_size.
REQ-013 SHALL hold arvalid, araddr, arid and arsize stable in ADDR until arready; arvalid is never withdrawn.
REQ-014 On arvalid && arready, SHALL pulse the selected requester's gnt for exactly that cycle; state -> DATA.
REQ-015 SHALL assert rready only in DATA.
REQ-016 On rvalid && rready with rid = the outstanding ID, SHALL register rdata into the matching *_rdata and pulse the matching *_rvalid one cycle later; state -> IDLE in the same edge.
REQ-017 R beats with rid not equal to the outstanding ID SHALL be accepted and discarded, with no state change.
REQ-018 *_rdata SHALL hold its value until the next *_rvalid pulse for that requester.
REQ-019 If flush is asserted in IDLE, SHALL not select inst in that cycle; data may be selected.
REQ-020 If flush is asserted while an inst transaction is in ADDR or DATA, SHALL set a discard flag; the AR/R handshakes complete normally; inst_gnt still pulses in ADDR; inst_rvalid is suppressed; the flag is cleared on return to IDLE.
REQ-021 Flush SHALL have no effect on data transactions.
REQ-022 Minimum turnaround SHALL be: next arvalid 2 cycles after the R handshake edge.

Reset
REQ-023 On aresetn low, SHALL immediately force state IDLE and discard flag 0.
REQ-024 On aresetn low, SHALL force arvalid, rready, inst_gnt, data_gnt, inst_rvalid and data_rvalid to 0, arid/araddr/arsize to 0, *_rdata to 0, and last-granted to inst.
REQ-025 Reset asserted mid-transaction SHALL abandon that transaction with no completion pulse.

Structure
REQ-026 Shared package SHALL hold INST_ID = 4'd0, DATA_ID = 4'd1, the state enum, and INST_ARSIZE = 3'b010.
REQ-027 The 2-way round-robin selection SHALL be the sub-module axi_rr_picker (req[1:0], last, sel); all other logic is in the top.

Verification
REQ-028 inst_req=1, inst_addr=0xBFC00000, arready=1 next cycle, R(rid=0, rdata=0x3C080001) -> one inst_gnt pulse, then inst_rvalid=1 with inst_rdata=0x3C080001 for one cycle.
REQ-029 inst_req and data_req both held high for 4 transactions -> arid sequence 1,0,1,0.
REQ-030 data read 0x80001000, data_size=0, arready held low for 5 cycles -> arvalid and araddr stable for all 6 cycles; arsize=0.
REQ-031 flush pulsed while an inst read is in DATA; response rdata=0xDEADBEEF arrives -> inst_rvalid stays 0; next transaction issues normally.
REQ-032 aresetn dropped while in ADDR -> arvalid=0 asynchronously; after release, a new data_req issues arid=1 with no stale pulses.
REQ-033 Stray R beat rid=2 while DATA with outstanding ID 1 -> beat discarded; state stays DATA; the correct rid=1 beat completes.

Source files
------------

// File: rtl/axi_read_arbiter_pkg.sv
// Shared constants and types for the two-requester AXI read arbiter.
package axi_read_arbiter_pkg;

    localparam logic [3:0] INST_ID     = 4'd0;
    localparam logic [3:0] DATA_ID     = 4'd1;
    localparam logic [2:0] INST_ARSIZE = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    // Encoding matches the picker's req/sel bit positions.
    typedef enum logic {
        REQ_INST = 1'b0,
        REQ_DATA = 1'b1
    } requester_e;

endpackage

// File: rtl/axi_read_arbiter_if.sv
// AXI read address and read data channels shared by the arbiter and its slave.
interface axi_read_arbiter_if;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, araddr, arsize, arvalid, rready,
        input  arready, rid, rdata, rvalid
    );

    modport slave (
        input  arid, araddr, arsize, arvalid, rready,
        output arready, rid, rdata, rvalid
    );

endinterface

// File: rtl/axi_rr_picker.sv
// Two-way round-robin picker: bit 0 = inst, bit 1 = data.
// With both requests pending the one not granted last wins; the output is
// only meaningful when at least one request is set.
module axi_rr_picker (
    input  logic [1:0] req,
    input  logic       last,
    output logic       sel
);

    // Single request wins outright; a tie goes to the other side from last.
    always_comb begin
        sel = ~last;
        if (req == 2'b01) begin
            sel = 1'b0;
        end else if (req == 2'b10) begin
            sel = 1'b1;
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Arbitrates instruction-fetch and load requesters onto a single AXI read
// port with at most one transaction outstanding.  A pipeline flush cancels
// an instruction read: it is either not selected, or its response is
// swallowed once the bus handshakes complete.
module axi_read_arbiter
    import axi_read_arbiter_pkg::*;
(
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                flush,

    input  logic                inst_req,
    input  logic [31:0]         inst_addr,
    output logic                inst_gnt,
    output logic                inst_rvalid,
    output logic [31:0]         inst_rdata,

    input  logic                data_req,
    input  logic [31:0]         data_addr,
    input  logic [2:0]          data_size,
    output logic                data_gnt,
    output logic                data_rvalid,
    output logic [31:0]         data_rdata,

    axi_read_arbiter_if.master  axi
);

    state_e      state_q, state_d;
    requester_e  cur_q;
    requester_e  last_q;
    logic        discard_q;
    logic [3:0]  arid_q;
    logic [31:0] araddr_q;
    logic [2:0]  arsize_q;
    logic        inst_rvalid_q, data_rvalid_q;
    logic [31:0] inst_rdata_q, data_rdata_q;

    logic [1:0]  req_eff;
    logic        sel;
    logic        pick;
    logic        ar_hs;
    logic        r_hs;

    // A flushed fetch request is invisible to arbitration in that cycle.
    assign req_eff = {data_req, inst_req & ~flush};

    axi_rr_picker u_picker (
        .req  (req_eff),
        .last (last_q),
        .sel  (sel)
    );

    assign pick  = (state_q == ST_IDLE) && (|req_eff);
    assign ar_hs = (state_q == ST_ADDR) && axi.arready;
    // Beats carrying a foreign ID are still accepted (rready is high) but ignored.
    assign r_hs  = (state_q == ST_DATA) && axi.rvalid && (axi.rid == arid_q);

    assign axi.arvalid = (state_q == ST_ADDR);
    assign axi.rready  = (state_q == ST_DATA);
    assign axi.arid    = arid_q;
    assign axi.araddr  = araddr_q;
    assign axi.arsize  = arsize_q;

    assign inst_gnt    = ar_hs && (cur_q == REQ_INST);
    assign data_gnt    = ar_hs && (cur_q == REQ_DATA);
    assign inst_rvalid = inst_rvalid_q;
    assign data_rvalid = data_rvalid_q;
    assign inst_rdata  = inst_rdata_q;
    assign data_rdata  = data_rdata_q;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> ADDR on selection, ADDR -> DATA on AR
    // handshake, DATA -> IDLE on the matching R beat.
    always_comb begin
        // NOTE: defaulting before the case keeps this purely combinational;
        // any path that left state_d unassigned would infer a latch.
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (pick)         state_d = ST_ADDR;
            ST_ADDR: if (axi.arready)  state_d = ST_DATA;
            ST_DATA: if (r_hs)         state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    // Capture the AR payload at selection; it stays frozen through ADDR.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cur_q    <= REQ_INST;
            arid_q   <= '0;
            araddr_q <= '0;
            arsize_q <= '0;
        end else if (pick) begin
            cur_q <= requester_e'(sel);
            if (sel) begin
                arid_q   <= DATA_ID;
                araddr_q <= data_addr;
                arsize_q <= data_size;
            end else begin
                arid_q   <= INST_ID;
                araddr_q <= inst_addr;
                arsize_q <= INST_ARSIZE;
            end
        end
    end

    // Round-robin history advances when a grant is actually issued.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            last_q <= REQ_INST;
        end else if (ar_hs) begin
            last_q <= cur_q;
        end
    end

    // Remember a flush that hits an in-flight fetch so its data is dropped.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            discard_q <= 1'b0;
        end else if ((state_q == ST_IDLE) || r_hs) begin
            discard_q <= 1'b0;
        end else if (flush && (cur_q == REQ_INST)) begin
            discard_q <= 1'b1;
        end
    end

    // Route the completing beat to its requester as a one-cycle pulse;
    // rdata registers hold until the next delivered beat.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            inst_rvalid_q <= 1'b0;
            data_rvalid_q <= 1'b0;
            inst_rdata_q  <= '0;
            data_rdata_q  <= '0;
        end else begin
            inst_rvalid_q <= 1'b0;
            data_rvalid_q <= 1'b0;
            if (r_hs) begin
                if (cur_q == REQ_DATA) begin
                    data_rvalid_q <= 1'b1;
                    data_rdata_q  <= axi.rdata;
                end else if (!(discard_q || flush)) begin
                    inst_rvalid_q <= 1'b1;
                    inst_rdata_q  <= axi.rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter.  Inputs change at the falling
// edge; outputs are sampled 1 ns later.  The reference model tracks only
// transaction-level facts: who should win arbitration, what the AR payload
// must be, and what each requester's read data register should hold.
module tb_axi_read_arbiter;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        flush;
    logic        inst_req, data_req;
    logic [31:0] inst_addr, data_addr;
    logic [2:0]  data_size;
    logic        inst_gnt, inst_rvalid, data_gnt, data_rvalid;
    logic [31:0] inst_rdata, data_rdata;

    axi_read_arbiter_if axi ();

    axi_read_arbiter dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .flush       (flush),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_gnt    (inst_gnt),
        .inst_rvalid (inst_rvalid),
        .inst_rdata  (inst_rdata),
        .data_req    (data_req),
        .data_addr   (data_addr),
        .data_size   (data_size),
        .data_gnt    (data_gnt),
        .data_rvalid (data_rvalid),
        .data_rdata  (data_rdata),
        .axi         (axi)
    );

    always #5 aclk = ~aclk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state.
    bit          exp_last;          // 0: inst granted last, 1: data
    logic [31:0] exp_inst_rdata;
    logic [31:0] exp_data_rdata;
    logic [3:0]  arid_log[$];

    task automatic model_reset();
        exp_last       = 1'b0;
        exp_inst_rdata = '0;
        exp_data_rdata = '0;
    endtask

    // Drop all requests and expect a quiet bus for n cycles.
    task automatic idle(input int n);
        inst_req = 1'b0; data_req = 1'b0; flush = 1'b0;
        axi.arready = 1'b0; axi.rvalid = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge aclk); #1;
            vectors++;
            if ({axi.arvalid, axi.rready, inst_gnt, data_gnt, inst_rvalid, data_rvalid,
                 inst_rdata, data_rdata} !== {6'b0, exp_inst_rdata, exp_data_rdata}) begin
                miscompares++;
                $display("FAIL idle: got ctl=%b rd=%h/%h expected ctl=000000 rd=%h/%h",
                         {axi.arvalid, axi.rready, inst_gnt, data_gnt, inst_rvalid, data_rvalid},
                         inst_rdata, data_rdata, exp_inst_rdata, exp_data_rdata);
            end
        end
    endtask

    // One complete read, entered during a cycle in which the arbiter is idle.
    // flush_at: 0 none, 1 in the selection cycle, 2 in ADDR, 3 in DATA.
    task automatic txn(input bit i, input bit d, input logic [31:0] ia,
                       input logic [31:0] da, input logic [2:0] dsz,
                       input int ar_delay, input int r_delay, input bit stray,
                       input int flush_at, input logic [31:0] rd);
        bit          ei, sel, discard;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [2:0]  sz;
        logic [1:0]  exp_gnt, exp_rv;

        ei      = i && (flush_at != 1);
        sel     = (ei && d) ? !exp_last : d;
        id      = sel ? 4'd1 : 4'd0;
        addr    = sel ? da : ia;
        sz      = sel ? dsz : 3'b010;
        discard = !sel && (flush_at == 2 || flush_at == 3);
        exp_gnt = sel ? 2'b01 : 2'b10;   // {inst_gnt, data_gnt}

        inst_req = i; inst_addr = ia; data_req = d; data_addr = da; data_size = dsz;
        flush = (flush_at == 1);
        @(negedge aclk); flush = 1'b0; #1;

        // Address phase: request visible one cycle after selection, held until arready.
        for (int k = 0; k <= ar_delay; k++) begin
            if (k > 0) begin
                @(negedge aclk); flush = 1'b0; #1;
            end
            axi.arready = (k == ar_delay);
            if (k == 0 && flush_at == 2) flush = 1'b1;
            #1;
            if (k == 0) arid_log.push_back(axi.arid);
            vectors++;
            if ({axi.arvalid, axi.arid, axi.araddr, axi.arsize, axi.rready, inst_rvalid, data_rvalid}
                    !== {1'b1, id, addr, sz, 3'b000}) begin
                miscompares++;
                $display("FAIL ar_hold c%0d: got v=%b id=%h a=%h s=%h rr=%b rv=%b%b expected v=1 id=%h a=%h s=%h rr=0 rv=00",
                         k, axi.arvalid, axi.arid, axi.araddr, axi.arsize, axi.rready,
                         inst_rvalid, data_rvalid, id, addr, sz);
            end
            vectors++;
            if ({inst_gnt, data_gnt} !== ((k == ar_delay) ? exp_gnt : 2'b00)) begin
                miscompares++;
                $display("FAIL gnt c%0d: got %b expected %b", k, {inst_gnt, data_gnt},
                         (k == ar_delay) ? exp_gnt : 2'b00);
            end
        end
        exp_last = sel;

        // Data phase.
        @(negedge aclk);
        axi.arready = 1'b0; flush = 1'b0;
        if (sel) data_req = 1'b0; else inst_req = 1'b0;
        if (flush_at == 3) flush = 1'b1;
        #1;
        vectors++;
        if ({axi.arvalid, axi.rready, inst_gnt, data_gnt} !== 4'b0100) begin
            miscompares++;
            $display("FAIL data_enter: got v/rr/g=%b expected 0100",
                     {axi.arvalid, axi.rready, inst_gnt, data_gnt});
        end
        for (int k = 0; k < r_delay; k++) begin
            @(negedge aclk); flush = 1'b0; #1;
            vectors++;
            if ({axi.rready, inst_rvalid, data_rvalid} !== 3'b100) begin
                miscompares++;
                $display("FAIL data_wait: got rr/rv=%b expected 100",
                         {axi.rready, inst_rvalid, data_rvalid});
            end
        end
        if (stray) begin
            @(negedge aclk); flush = 1'b0;
            axi.rvalid = 1'b1; axi.rid = 4'd2; axi.rdata = ~rd;
            @(negedge aclk); axi.rvalid = 1'b0; #1;
            vectors++;
            if ({axi.rready, inst_rvalid, data_rvalid} !== 3'b100) begin
                miscompares++;
                $display("FAIL stray: got rr/rv=%b expected 100",
                         {axi.rready, inst_rvalid, data_rvalid});
            end
        end
        @(negedge aclk); flush = 1'b0;
        axi.rvalid = 1'b1; axi.rid = id; axi.rdata = rd;
        @(negedge aclk); axi.rvalid = 1'b0; #1;

        if (sel) exp_data_rdata = rd;
        else if (!discard) exp_inst_rdata = rd;
        exp_rv = sel ? 2'b01 : (discard ? 2'b00 : 2'b10);   // {inst_rvalid, data_rvalid}
        vectors++;
        if ({axi.rready, axi.arvalid, inst_rvalid, data_rvalid, inst_rdata, data_rdata}
                !== {2'b00, exp_rv, exp_inst_rdata, exp_data_rdata}) begin
            miscompares++;
            $display("FAIL resp: got rr/v=%b%b rv=%b%b rd=%h/%h expected rr/v=00 rv=%b rd=%h/%h",
                     axi.rready, axi.arvalid, inst_rvalid, data_rvalid, inst_rdata, data_rdata,
                     exp_rv, exp_inst_rdata, exp_data_rdata);
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b1; flush = 1'b0; inst_req = 1'b0; data_req = 1'b0;
        inst_addr = '0; data_addr = '0; data_size = '0;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rid = '0; axi.rdata = '0;
        #2 aresetn = 1'b0;
        #2;
        model_reset();
        vectors++;
        if ({axi.arvalid, axi.rready, inst_gnt, data_gnt, inst_rvalid, data_rvalid,
             axi.arid, axi.araddr, axi.arsize, inst_rdata, data_rdata} !== '0) begin
            miscompares++;
            $display("FAIL reset: got v=%b rr=%b id=%h a=%h s=%h rd=%h/%h expected all zero",
                     axi.arvalid, axi.rready, axi.arid, axi.araddr, axi.arsize, inst_rdata, data_rdata);
        end
        @(negedge aclk); aresetn = 1'b1; #1;
        idle(2);
    endtask

    task automatic test_basic_fetch();
        txn(1'b1, 1'b0, 32'hBFC0_0000, '0, '0, 0, 0, 1'b0, 0, 32'h3C08_0001);
        vectors++;
        if (inst_rdata !== 32'h3C08_0001) begin
            miscompares++;
            $display("FAIL fetch_rdata: got %h expected 3c080001", inst_rdata);
        end
        idle(1);
    endtask

    task automatic test_round_robin();
        logic [3:0] want [4] = '{4'd1, 4'd0, 4'd1, 4'd0};
        // Restore the post-reset history so the pattern starts with data.
        exp_last = 1'b0;
        arid_log.delete();
        for (int n = 0; n < 4; n++)
            txn(1'b1, 1'b1, 32'h1000_0000 + 32'(n * 4), 32'h2000_0000 + 32'(n * 4), 3'd2,
                n % 2, n % 3, 1'b0, 0, $urandom);
        idle(1);
        for (int n = 0; n < 4; n++) begin
            vectors++;
            if (arid_log.size() <= n || arid_log[n] !== want[n]) begin
                miscompares++;
                $display("FAIL rr_seq[%0d]: got %h expected %h", n,
                         (arid_log.size() > n) ? arid_log[n] : 4'hx, want[n]);
            end
        end
    endtask

    task automatic test_arready_stall();
        txn(1'b0, 1'b1, '0, 32'h8000_1000, 3'd0, 5, 1, 1'b0, 0, 32'h1234_5678);
        idle(1);
    endtask

    task automatic test_flush();
        // Flush in DATA: inst response dropped, next read normal.
        txn(1'b1, 1'b0, 32'h0000_0100, '0, '0, 0, 1, 1'b0, 3, 32'hDEAD_BEEF);
        txn(1'b1, 1'b0, 32'h0000_0104, '0, '0, 0, 0, 1'b0, 0, 32'hCAFE_0001);
        // Flush in ADDR: grant still pulses, data dropped.
        txn(1'b1, 1'b0, 32'h0000_0108, '0, '0, 2, 0, 1'b0, 2, 32'h5555_AAAA);
        txn(1'b1, 1'b0, 32'h0000_010C, '0, '0, 0, 0, 1'b0, 2, 32'h6666_BBBB);
        // Flush has no effect on a data read.
        txn(1'b0, 1'b1, '0, 32'h9000_0000, 3'd1, 1, 0, 1'b0, 3, 32'h7777_CCCC);
        // Flush in IDLE with both pending: data wins regardless of history.
        exp_last = 1'b1;
        txn(1'b1, 1'b1, 32'h0000_0200, 32'h9000_0010, 3'd2, 0, 0, 1'b0, 1, 32'h8888_DDDD);
        idle(1);
        // Flush in IDLE with only inst pending: nothing issues that cycle.
        inst_req = 1'b1; inst_addr = 32'h0000_0300; flush = 1'b1;
        @(negedge aclk); flush = 1'b0; #1;
        vectors++;
        if (axi.arvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_idle: got arvalid=%b expected 0", axi.arvalid);
        end
        txn(1'b1, 1'b0, 32'h0000_0300, '0, '0, 0, 0, 1'b0, 0, 32'h9999_EEEE);
        idle(1);
    endtask

    task automatic test_stray_beat();
        txn(1'b0, 1'b1, '0, 32'h8000_2000, 3'd2, 0, 1, 1'b1, 0, 32'hA5A5_0033);
        txn(1'b1, 1'b0, 32'h0000_0400, '0, '0, 1, 0, 1'b1, 0, 32'hA5A5_0044);
        idle(1);
    endtask

    task automatic test_reset_mid();
        inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h8000_3000; data_size = 3'd2;
        @(negedge aclk); #1;
        vectors++;
        if ({axi.arvalid, axi.arid} !== {1'b1, 4'd1}) begin
            miscompares++;
            $display("FAIL rst_pre: got v=%b id=%h expected v=1 id=1", axi.arvalid, axi.arid);
        end
        #1 aresetn = 1'b0; data_req = 1'b0;
        #1;
        model_reset();
        vectors++;
        if ({axi.arvalid, axi.rready, inst_gnt, data_gnt, inst_rvalid, data_rvalid,
             axi.arid, axi.araddr, axi.arsize, inst_rdata, data_rdata} !== '0) begin
            miscompares++;
            $display("FAIL rst_mid: got v=%b rr=%b id=%h a=%h s=%h rd=%h/%h expected all zero",
                     axi.arvalid, axi.rready, axi.arid, axi.araddr, axi.arsize, inst_rdata, data_rdata);
        end
        @(negedge aclk); aresetn = 1'b1; #1;
        idle(3);
        txn(1'b0, 1'b1, '0, 32'h8000_3004, 3'd2, 0, 0, 1'b0, 0, 32'h0BAD_F00D);
        txn(1'b1, 1'b1, 32'h0000_0500, 32'h8000_3008, 3'd1, 0, 0, 1'b0, 0, 32'h1357_9BDF);
        idle(1);
    endtask

    task automatic test_random();
        bit i, d;
        int fa;
        for (int n = 0; n < 24; n++) begin
            i = $urandom_range(0, 1);
            d = $urandom_range(0, 1);
            if (!i && !d) d = 1'b1;
            fa = $urandom_range(0, 3);
            if (fa == 1 && !d) fa = 0;
            txn(i, d, $urandom, $urandom, 3'($urandom_range(0, 2)),
                $urandom_range(0, 3), $urandom_range(0, 3),
                ($urandom_range(0, 3) == 0), fa, $urandom);
        end
        idle(2);
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_round_robin();
        test_arready_stall();
        test_flush();
        test_stray_beat();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
